updn_counter: RTL

UPDN_COUNTER -- requirements
Module: updn_counter

---
 rtl/counter_pkg.sv | 10 +
 rtl/counter_prescaler.sv | 40 ++++
 rtl/updn_counter.sv | 91 +++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter slice: direction encoding and default sizing.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int unsigned DEFAULT_WIDTH    = 8;
    localparam int unsigned DEFAULT_PRESCALE = 1;

endpackage : counter_pkg

// File: rtl/counter_prescaler.sv
// Enable prescaler: asserts tick on every PRESCALE-th enabled cycle; tick follows en when PRESCALE=1.
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    // A 1-bit phase that never leaves 0 covers PRESCALE=1 without a separate code path.
    localparam int unsigned PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase;
    logic [PW-1:0] phase_d;

    always_comb begin
        phase_d = phase;
        if (clr) begin
            phase_d = '0;
        end else if (en) begin
            phase_d = (phase == LAST) ? '0 : phase + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
        end else begin
            phase <= phase_d;
        end
    end

    assign tick = en && (phase == LAST);

endmodule : counter_prescaler

// File: rtl/updn_counter.sv
// Modulo-(MAX_VAL+1) up/down counter with load, clear, prescaled enable, tc pulse and sticky ovf.
// Define UPDN_COUNTER_SAT_EN to saturate at the ends instead of wrapping.
module updn_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned MAX_VAL  = (2 ** WIDTH) - 1,
    parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX_VAL);

    logic             tick;
    logic             wrap;
    logic [WIDTH-1:0] count_d;
    logic             tc_d;
    logic             ovf_d;

    // Clear and load both restart the prescaler phase.
    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr | load),
        .en   (en),
        .tick (tick)
    );

    // Priority: clr > load > step > hold.
    always_comb begin
        count_d = count;
        wrap    = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = (load_val > TOP) ? TOP : load_val;
        end else if (tick) begin
            if (up == DIR_UP) begin
                if (count >= TOP) begin
                    wrap = 1'b1;
`ifdef UPDN_COUNTER_SAT_EN
                    count_d = TOP;
`else
                    count_d = '0;
`endif
                end else begin
                    count_d = count + WIDTH'(1);
                end
            end else begin
                if (count == '0) begin
                    wrap = 1'b1;
`ifdef UPDN_COUNTER_SAT_EN
                    count_d = '0;
`else
                    count_d = TOP;
`endif
                end else begin
                    count_d = count - WIDTH'(1);
                end
            end
        end
        tc_d  = wrap;
        ovf_d = wrap ? 1'b1 : (ovf_clr ? 1'b0 : ovf);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            count <= count_d;
            tc    <= tc_d;
            ovf   <= ovf_d;
        end
    end

endmodule : updn_counter
